// File: rtl/b5_dec_onehot_seq.sv
// b5_dec_onehot_seq: sequenced binary-to-one-hot decoder (inverse of the b5 priority encoder).
//
// An index accepted through a valid/ready handshake is decoded to a registered one-hot
// pattern. The pattern is held for HOLD_CYCLES enabled cycles and then cleared. The block
// then spends at least one cycle in IDLE before it can accept the next index.
//
// Ports:
//   clock       in   rising-edge system clock
//   reset_n     in   asynchronous active-low reset
//   enable      in   global run/freeze control; freezes the hold when low
//   bin_in      in   IN_W-bit index to decode
//   in_valid    in   bin_in is valid this cycle
//   in_ready    out  block can accept an index this cycle (combinational)
//   decoder_out out  registered one-hot pattern, all-zero when idle
//   out_valid   out  decoder_out holds a decoded value
//   busy        out  state is HOLD
//   scan_mode   in   (DEC_SCAN_EN only) self-sweep all output bits
//
// Optional feature: define DEC_SCAN_EN to add the scan_mode port and the internal scan index.
// OUT_W must equal 2**IN_W; HOLD_CYCLES must lie in 1..255.

module b5_dec_onehot_seq #(
  parameter int unsigned IN_W        = 4,
  parameter int unsigned OUT_W       = 16,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
`ifdef DEC_SCAN_EN
  input  logic             scan_mode,
`endif
  input  logic [IN_W-1:0]  bin_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] decoder_out,
  output logic             out_valid,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  // Counter is loaded with HOLD_CYCLES-1 so that the HOLD state spans exactly HOLD_CYCLES
  // enabled edges, including the one on which the counter reaches zero.
  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

  state_e           state_q;
  logic [7:0]       cnt_q;
  logic             scan_active;
  logic [IN_W-1:0]  accept_idx;
  logic [OUT_W-1:0] onehot;
  logic             accept;

`ifdef DEC_SCAN_EN
  logic [IN_W-1:0]  scan_idx_q;

  assign scan_active = scan_mode;
  assign accept_idx  = scan_active ? scan_idx_q : bin_in;
`else
  assign scan_active = 1'b0;
  assign accept_idx  = bin_in;
`endif

  // reset_n is included so in_ready is low for the whole time reset is asserted.
  assign in_ready = reset_n & enable & (state_q == StIdle) & ~scan_active;

  // In scan mode the block self-accepts; external in_valid is ignored.
  assign accept = (state_q == StIdle) & (scan_active | (in_valid & in_ready));

  assign onehot = {{(OUT_W-1){1'b0}}, 1'b1} << accept_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      decoder_out <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
`ifdef DEC_SCAN_EN
      scan_idx_q  <= '0;
`endif
    end else if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            decoder_out <= onehot;
            out_valid   <= 1'b1;
            busy        <= 1'b1;
            cnt_q       <= HoldLast;
            state_q     <= StHold;
`ifdef DEC_SCAN_EN
            // Natural IN_W-bit wrap takes OUT_W-1 back to 0.
            if (scan_active) begin
              scan_idx_q <= scan_idx_q + 1'b1;
            end
`endif
          end
        end
        StHold: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            state_q     <= StIdle;
            decoder_out <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_b5_dec_onehot_seq.sv
// Directed self-checking bench for b5_dec_onehot_seq (HOLD_CYCLES=4 instance; with
// DEC_SCAN_EN a second HOLD_CYCLES=1 instance exercises the scan sweep).

module tb_b5_dec_onehot_seq;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [3:0]  bin_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] decoder_out;
  logic        out_valid;
  logic        busy;

  int total;
  int bad;

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef DEC_SCAN_EN
  logic        scan_mode;
  logic        s_scan_mode;
  logic [3:0]  s_bin_in;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [15:0] s_decoder_out;
  logic        s_out_valid;
  logic        s_busy;
`endif

  b5_dec_onehot_seq #(
    .IN_W       (4),
    .OUT_W      (16),
    .HOLD_CYCLES(4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
`ifdef DEC_SCAN_EN
    .scan_mode  (scan_mode),
`endif
    .bin_in     (bin_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .decoder_out(decoder_out),
    .out_valid  (out_valid),
    .busy       (busy)
  );

`ifdef DEC_SCAN_EN
  b5_dec_onehot_seq #(
    .IN_W       (4),
    .OUT_W      (16),
    .HOLD_CYCLES(1)
  ) dut_scan (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .scan_mode  (s_scan_mode),
    .bin_in     (s_bin_in),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .decoder_out(s_decoder_out),
    .out_valid  (s_out_valid),
    .busy       (s_busy)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Decode one index from IDLE, check the pattern, then drain the 4-cycle hold.
  task automatic decode_one(input int idx);
    bin_in   = 4'(idx);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check($sformatf("sweep_dec_%0d", idx), 32'(decoder_out), 32'(1) << idx);
    check($sformatf("sweep_ones_%0d", idx), 32'($countones(decoder_out)), 32'd1);
    repeat (4) tick();
    check($sformatf("sweep_idle_%0d", idx), 32'(out_valid), 32'd0);
  endtask

  initial begin
    int hi;
    total    = 0;
    bad      = 0;
    reset_n  = 1'b0;
    enable   = 1'b1;
    bin_in   = 4'd7;
    in_valid = 1'b1;
`ifdef DEC_SCAN_EN
    scan_mode   = 1'b0;
    s_scan_mode = 1'b0;
    s_bin_in    = 4'd7;
    s_in_valid  = 1'b0;
`endif

    // 1. Reset with in_valid high.
    repeat (3) tick();
    check("rst_dec", 32'(decoder_out), 32'h0000);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    check("rel_ready", 32'(in_ready), 32'd1);
    tick();

    // 2. Single decode of 5, held 4 cycles.
    bin_in   = 4'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold_dec_%0d", i), 32'(decoder_out), 32'h0020);
      check($sformatf("hold_ov_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("hold_ready_%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("hold_busy_%0d", i), 32'(busy), 32'd1);
      tick();
    end
    check("after_dec", 32'(decoder_out), 32'h0000);
    check("after_ov", 32'(out_valid), 32'd0);
    check("after_ready", 32'(in_ready), 32'd1);

    // 3. Boundaries and full sweep.
    decode_one(0);
    decode_one(15);
    for (int k = 0; k < 16; k++) decode_one(k);

    // 4. Continuous in_valid: 3 decoded, 9 accepted on the first IDLE cycle.
    bin_in   = 4'd3;
    in_valid = 1'b1;
    tick();
    bin_in = 4'd9;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont_dec3_%0d", i), 32'(decoder_out), 32'h0008);
      tick();
    end
    check("cont_idle_ov", 32'(out_valid), 32'd0);
    check("cont_idle_ready", 32'(in_ready), 32'd1);
    tick();
    check("cont_dec9", 32'(decoder_out), 32'h0200);
    in_valid = 1'b0;
    repeat (4) tick();
    check("cont_drain", 32'(out_valid), 32'd0);

    // enable=0 in IDLE blocks the handshake.
    enable = 1'b0;
    #1;
    check("idle_frz_ready", 32'(in_ready), 32'd0);
    enable = 1'b1;

    // 5a. Freeze for 3 cycles at hold count 2: out_valid high 4+3 samples.
    bin_in   = 4'd2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) hi++;
      if (i >= 1 && i < 4) begin
        check($sformatf("frz_dec_%0d", i), 32'(decoder_out), 32'h0004);
      end
      enable = !(i >= 1 && i < 4);
      tick();
    end
    enable = 1'b1;
    check("frz_hi_cycles", 32'(hi), 32'd7);

    // 5b. Reset pulse mid-HOLD clears asynchronously, no resumption.
    bin_in   = 4'd11;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("mid_pre_dec", 32'(decoder_out), 32'h0800);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_dec", 32'(decoder_out), 32'h0000);
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    #1;
    reset_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) hi++;
    end
    check("mid_no_resume", 32'(hi), 32'd0);

`ifdef DEC_SCAN_EN
    // 6. Scan sweep with HOLD_CYCLES=1; external valid held high is ignored.
    s_scan_mode = 1'b1;
    s_in_valid  = 1'b1;
    #1;
    check("scan_ready", 32'(s_in_ready), 32'd0);
    for (int k = 0; k < 34; k++) begin
      tick();
      check($sformatf("scan_seq_%0d", k), 32'(s_decoder_out),
            (k % 2 == 0) ? (32'(1) << ((k / 2) % 16)) : 32'd0);
      check($sformatf("scan_rdy_%0d", k), 32'(s_in_ready), 32'd0);
    end
    s_scan_mode = 1'b0;
    s_in_valid  = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
